// File: rtl/mul_share_arbiter.sv
// Two-client round-robin arbiter/sequencer for the shared 4x4 shift-add multiplier.
// Latches one job at a time, pulses start, waits MUL_LAT edges, returns the product.
module mul_share_arbiter #(
  parameter int MUL_LAT = 5
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] m0,
  input  logic [3:0] q0,
  input  logic [3:0] m1,
  input  logic [3:0] q1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] res,
  output logic       busy,
  output logic       mul_start,
  output logic [3:0] mul_m,
  output logic [3:0] mul_q,
  input  logic [7:0] mul_p
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_sel, w_sel_nxt;
  logic       r_last, w_last_nxt;
  logic [3:0] r_mul_m, w_mul_m_nxt;
  logic [3:0] r_mul_q, w_mul_q_nxt;
  logic [7:0] r_res, w_res_nxt;
  logic       r_ack0, r_ack1, r_done0, r_done1, r_busy, r_mul_start;
  logic       w_win;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_mul_m_nxt = r_mul_m;
    w_mul_q_nxt = r_mul_q;
    w_res_nxt   = r_res;
    w_win       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 | req1) begin
          // On a tie the client that did not finish last wins.
          w_win       = (req0 & req1) ? ~r_last : req1;
          w_sel_nxt   = w_win;
          w_mul_m_nxt = w_win ? m1 : m0;
          w_mul_q_nxt = w_win ? q1 : q0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_cnt_nxt   = 4'(MUL_LAT - 1);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_res_nxt   = mul_p;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_last_nxt  = r_sel;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pulse outputs are decoded from the next state so they come straight from flops.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_sel       <= 1'b0;
      r_last      <= 1'b1;
      r_mul_m     <= 4'd0;
      r_mul_q     <= 4'd0;
      r_res       <= 8'd0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_busy      <= 1'b0;
      r_mul_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sel       <= w_sel_nxt;
      r_last      <= w_last_nxt;
      r_mul_m     <= w_mul_m_nxt;
      r_mul_q     <= w_mul_q_nxt;
      r_res       <= w_res_nxt;
      r_ack0      <= (w_state_nxt == S_START) & ~w_sel_nxt;
      r_ack1      <= (w_state_nxt == S_START) &  w_sel_nxt;
      r_done0     <= (w_state_nxt == S_DONE)  & ~w_sel_nxt;
      r_done1     <= (w_state_nxt == S_DONE)  &  w_sel_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_mul_start <= (w_state_nxt == S_START);
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign busy      = r_busy;
  assign mul_start = r_mul_start;
  assign mul_m     = r_mul_m;
  assign mul_q     = r_mul_q;
  assign res       = r_res;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: two instances (MUL_LAT=5 and 1) share the clock,
// behavioural multipliers drive X until the product is due, scoreboard checks ack/done.
module tb_mul_share_arbiter;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic [1:0]      req0, req1, ack0, ack1, done0, done1, busy, mul_start;
  logic [1:0][3:0] m0, q0, m1, q1, mul_m, mul_q;
  logic [1:0][7:0] res, mul_p;

  function automatic int lat(int u);
    return (u == 0) ? 5 : 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mul_share_arbiter #(.MUL_LAT(g == 0 ? 5 : 1)) dut (
      .clk(clk), .n_rst(n_rst),
      .req0(req0[g]), .req1(req1[g]),
      .m0(m0[g]), .q0(q0[g]), .m1(m1[g]), .q1(q1[g]),
      .ack0(ack0[g]), .ack1(ack1[g]), .done0(done0[g]), .done1(done1[g]),
      .res(res[g]), .busy(busy[g]), .mul_start(mul_start[g]),
      .mul_m(mul_m[g]), .mul_q(mul_q[g]), .mul_p(mul_p[g])
    );
  end

  // Multiplier model: product becomes valid just before the MUL_LAT-th edge after start.
  int         mcnt  [2];
  logic [7:0] mprod [2];
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int u = 0; u < 2; u++) begin
        mcnt[u]  <= 0;
        mprod[u] <= 8'h00;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (mul_start[u]) begin
          mcnt[u]  <= lat(u);
          mprod[u] <= 8'(mul_m[u]) * 8'(mul_q[u]);
        end else if (mcnt[u] > 0) begin
          mcnt[u] <= mcnt[u] - 1;
        end
      end
    end
  end

  always_comb begin
    mul_p = '0;
    for (int u = 0; u < 2; u++) mul_p[u] = (mcnt[u] > 1) ? 8'hxx : mprod[u];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         u;
    logic [1:0] who;
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] p;
    int         cyc;
  } ev_t;

  ev_t q_ack[$];
  ev_t q_done[$];
  int  vec = 0;
  int  bad = 0;
  logic [3:0] pp [2] = '{4'b0, 4'b0};

  always @(negedge clk) begin : mon
    ev_t e;
    logic [3:0] cur;
    for (int u = 0; u < 2; u++) begin
      cur = {ack0[u], ack1[u], done0[u], done1[u]};
      if (cur != 4'b0) begin
        vec++;
        assert ((cur & pp[u]) === 4'b0)
          else begin bad++; $error("FAIL pulse_width u=%0d got cur=%b prev=%b", u, cur, pp[u]); end
      end
      pp[u] <= cur;
      if (mul_start[u] | ack0[u] | ack1[u]) begin
        vec++;
        assert (mul_start[u] === (ack0[u] | ack1[u]))
          else begin bad++; $error("FAIL start_only_in_start u=%0d got start=%b ack=%b%b", u, mul_start[u], ack1[u], ack0[u]); end
      end
      if (ack0[u] | ack1[u]) begin
        e = '{u: -1, who: 2'b00, m: 4'h0, q: 4'h0, p: 8'h00, cyc: -1};
        if (q_ack.size() != 0) e = q_ack.pop_front();
        vec++;
        assert ({u, ack1[u], ack0[u], mul_m[u], mul_q[u], busy[u], cyc} === {e.u, e.who, e.m, e.q, 1'b1, e.cyc})
          else begin bad++; $error("FAIL ack u=%0d got who=%b m=%h q=%h busy=%b cyc=%0d exp u=%0d who=%b m=%h q=%h cyc=%0d",
                                    u, {ack1[u], ack0[u]}, mul_m[u], mul_q[u], busy[u], cyc, e.u, e.who, e.m, e.q, e.cyc); end
      end
      if (done0[u] | done1[u]) begin
        e = '{u: -1, who: 2'b00, m: 4'h0, q: 4'h0, p: 8'h00, cyc: -1};
        if (q_done.size() != 0) e = q_done.pop_front();
        vec++;
        assert ({u, done1[u], done0[u], res[u], busy[u], cyc} === {e.u, e.who, e.p, 1'b1, e.cyc})
          else begin bad++; $error("FAIL done u=%0d got who=%b res=%h busy=%b cyc=%0d exp u=%0d who=%b res=%h cyc=%0d",
                                    u, {done1[u], done0[u]}, res[u], busy[u], cyc, e.u, e.who, e.p, e.cyc); end
      end
    end
  end

  // g is the grant edge index; ack is seen in cycle g, done in cycle g+MUL_LAT+1.
  task automatic exp_job(input int u, input int who, input logic [3:0] m, input logic [3:0] q,
                         input int g, input bit with_done);
    ev_t e;
    e.u = u; e.who = (who == 1) ? 2'b10 : 2'b01; e.m = m; e.q = q;
    e.p = 8'(m) * 8'(q); e.cyc = g;
    q_ack.push_back(e);
    if (with_done) begin
      e.cyc = g + lat(u) + 1;
      q_done.push_back(e);
    end
  endtask

  task automatic wait_ack(input int u, input int who);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((who == 1) ? ack1[u] : ack0[u]) && n < 40);
    vec++;
    assert (((who == 1) ? ack1[u] : ack0[u]) === 1'b1)
      else begin bad++; $error("FAIL ack_timeout u=%0d who=%0d got none exp ack within 40 cycles", u, who); end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_done.size() != 0 || q_ack.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    vec++;
    assert (q_done.size() == 0 && q_ack.size() == 0)
      else begin bad++; $error("FAIL drain u_pending ack=%0d done=%0d exp 0 0", q_ack.size(), q_done.size()); end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_basic(input int u);
    int c;
    // Single job from client 0, then client 1 requests mid-job.
    c = cyc;
    req0[u] = 1'b1; m0[u] = 4'b1011; q0[u] = 4'b0110;
    exp_job(u, 0, 4'b1011, 4'b0110, c + 1, 1'b1);
    wait_ack(u, 0);
    req0[u] = 1'b0; m0[u] = 4'h0; q0[u] = 4'h0;
    @(negedge clk);
    req1[u] = 1'b1; m1[u] = 4'b0011; q1[u] = 4'b1011;
    exp_job(u, 1, 4'b0011, 4'b1011, c + 1 + lat(u) + 3, 1'b1);
    wait_ack(u, 1);
    req1[u] = 1'b0; m1[u] = 4'h0; q1[u] = 4'h0;
    drain();
    // Both held: strict alternation starting with client 0.
    c = cyc;
    req0[u] = 1'b1; m0[u] = 4'b1111; q0[u] = 4'b1111;
    req1[u] = 1'b1; m1[u] = 4'b0000; q1[u] = 4'b1010;
    for (int k = 0; k < 4; k++)
      exp_job(u, k % 2, (k % 2) ? 4'b0000 : 4'b1111, (k % 2) ? 4'b1010 : 4'b1111,
              c + 1 + k * (lat(u) + 3), 1'b1);
    wait_ack(u, 0);
    wait_ack(u, 1);
    wait_ack(u, 0);
    req0[u] = 1'b0;
    wait_ack(u, 1);
    req1[u] = 1'b0;
    drain();
  endtask

  initial begin
    int c, r;
    n_rst = 1'b0;
    req0 = '0; req1 = '0; m0 = '0; q0 = '0; m1 = '0; q1 = '0;
    #8;
    for (int u = 0; u < 2; u++) begin
      vec++;
      assert ({ack0[u], ack1[u], done0[u], done1[u], busy[u], mul_start[u], mul_m[u], mul_q[u], res[u]} === 22'h0)
        else begin bad++; $error("FAIL reset_state u=%0d got %h exp 0", u,
                                  {ack0[u], ack1[u], done0[u], done1[u], busy[u], mul_start[u], mul_m[u], mul_q[u], res[u]}); end
    end
    #3 n_rst = 1'b1;
    repeat (2) @(negedge clk);

    run_basic(0);

    // Lone requester gets back-to-back grants.
    c = cyc;
    req1[0] = 1'b1; m1[0] = 4'b0001; q1[0] = 4'b0111;
    for (int k = 0; k < 3; k++) exp_job(0, 1, 4'b0001, 4'b0111, c + 1 + k * 8, 1'b1);
    wait_ack(0, 1);
    wait_ack(0, 1);
    wait_ack(0, 1);
    req1[0] = 1'b0;
    drain();

    // Finish a client-0 job so the pointer favours client 1, then reset mid-WAIT.
    c = cyc;
    req0[0] = 1'b1; m0[0] = 4'h2; q0[0] = 4'h3;
    exp_job(0, 0, 4'h2, 4'h3, c + 1, 1'b1);
    wait_ack(0, 0);
    req0[0] = 1'b0;
    drain();
    c = cyc;
    req0[0] = 1'b1; m0[0] = 4'h5; q0[0] = 4'h5;
    exp_job(0, 0, 4'h5, 4'h5, c + 1, 1'b0);
    wait_ack(0, 0);
    req1[0] = 1'b1; m1[0] = 4'h4; q1[0] = 4'h6;
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    vec++;
    assert ({ack0[0], ack1[0], done0[0], done1[0], busy[0], mul_start[0]} === 6'b0)
      else begin bad++; $error("FAIL async_reset_ctl got %b exp 000000", {ack0[0], ack1[0], done0[0], done1[0], busy[0], mul_start[0]}); end
    vec++;
    assert ({mul_m[0], mul_q[0]} === 8'h00)
      else begin bad++; $error("FAIL async_reset_ops got %h exp 00", {mul_m[0], mul_q[0]}); end
    vec++;
    assert (res[0] === 8'h00)
      else begin bad++; $error("FAIL async_reset_res got %h exp 00", res[0]); end
    @(negedge clk);
    n_rst = 1'b1;
    r = cyc;
    exp_job(0, 0, 4'h5, 4'h5, r + 1, 1'b1);
    exp_job(0, 1, 4'h4, 4'h6, r + 9, 1'b1);
    wait_ack(0, 0);
    req0[0] = 1'b0;
    wait_ack(0, 1);
    req1[0] = 1'b0;
    drain();

    run_basic(1);

    vec++;
    assert (q_ack.size() == 0 && q_done.size() == 0)
      else begin bad++; $error("FAIL leftover got ack=%0d done=%0d exp 0 0", q_ack.size(), q_done.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
